csr_timer: RTL

- Programmable 32-bit timer peripheral on the CSR bus, downstream of the Wishbone-to-CSR bridge, alongside gpio, uart and sysctl.
- Counts prescaled sys_clk ticks up to a compare value, then raises a sticky event flag and a level interrupt.
- Supports one-shot and auto-restart modes.
- Its read data is OR-ed into the bridge's csr_di with the other peripherals.

---
 rtl/csr_timer.sv | 110 +++++++++++
 1 files changed

// File: rtl/csr_timer.sv
// Programmable 32-bit CSR timer: prescaled tick, compare match with sticky
// pending flag, one-shot or auto-restart, registered level interrupt.
module csr_timer #(
  parameter logic [3:0] csr_addr = 4'h4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [13:0] csr_a,
  input  logic        csr_we,
  input  logic [31:0] csr_di,
  output logic [31:0] csr_do,
  output logic        irq
);

  localparam logic [2:0] REG_CTRL     = 3'd0;
  localparam logic [2:0] REG_COMPARE  = 3'd1;
  localparam logic [2:0] REG_COUNTER  = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;
  localparam logic [2:0] REG_STATUS   = 3'd4;

  logic        en;
  logic        autorestart;
  logic        irq_en;
  logic [31:0] compare;
  logic [31:0] counter;
  logic [15:0] prescale;
  logic        pending;
  logic [15:0] pcnt;

  logic        sel;
  logic [2:0]  idx;
  logic        wr;
  logic        tick;
  logic        match;
  logic [31:0] rd_data;

  // Address bits between the page and the register index are don't-care.
  logic unused_addr;
  assign unused_addr = ^csr_a[9:3];

  assign sel   = (csr_a[13:10] == csr_addr);
  assign idx   = csr_a[2:0];
  assign wr    = sel & csr_we;
  assign tick  = en & (pcnt == prescale);
  assign match = tick & (counter == compare);

  always_comb begin
    // NOTE: assigning a default before the case keeps this purely
    // combinational; a missing branch would otherwise infer a latch.
    rd_data = '0;
    if (sel) begin
      case (idx)
        REG_CTRL:     rd_data = {29'd0, irq_en, autorestart, en};
        REG_COMPARE:  rd_data = compare;
        REG_COUNTER:  rd_data = counter;
        REG_PRESCALE: rd_data = {16'd0, prescale};
        REG_STATUS:   rd_data = {31'd0, pending};
        default:      rd_data = '0;
      endcase
    end
  end

  // NOTE: non-blocking assignments throughout, so every right-hand side sees
  // pre-edge values; this is what makes reads return pre-update state.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      en          <= 1'b0;
      autorestart <= 1'b0;
      irq_en      <= 1'b0;
      compare     <= '0;
      counter     <= '0;
      prescale    <= '0;
      pending     <= 1'b0;
      pcnt        <= '0;
      csr_do      <= '0;
      irq         <= 1'b0;
    end else begin
      csr_do <= rd_data;
      irq    <= pending & irq_en;

      if (wr && idx == REG_COMPARE)  compare  <= csr_di;
      if (wr && idx == REG_PRESCALE) prescale <= csr_di[15:0];

      if (wr && idx == REG_CTRL) begin
        autorestart <= csr_di[1];
        irq_en      <= csr_di[2];
      end

      // A CTRL write overrides the one-shot self-disable.
      if (wr && idx == REG_CTRL)       en <= csr_di[0];
      else if (match && !autorestart)  en <= 1'b0;

      // A COUNTER write overrides the tick update and restarts the prescaler.
      if (wr && idx == REG_COUNTER) begin
        counter <= csr_di;
        pcnt    <= '0;
      end else if (tick) begin
        counter <= match ? 32'd0 : counter + 32'd1;
        pcnt    <= '0;
      end else if (en) begin
        pcnt    <= pcnt + 16'd1;
      end

      // A match in the same cycle wins over a software clear.
      if (match)                                  pending <= 1'b1;
      else if (wr && idx == REG_STATUS && csr_di[0]) pending <= 1'b0;
    end
  end

endmodule
